// File: rtl/bus_interface_inputs_pkg.sv
// Shared definitions for the bus-mapped input peripheral: register bank
// selectors, IRQ handshake states and the bytes-per-bank helper.
package bus_interface_inputs_pkg;

    typedef enum logic [1:0] {
        BANK_STATE  = 2'd0,
        BANK_CHANGE = 2'd1,
        BANK_MASK   = 2'd2,
        BANK_NONE   = 2'd3
    } bank_e;

    typedef enum logic {
        IRQ_IDLE   = 1'b0,
        IRQ_RAISED = 1'b1
    } irq_state_e;

    // Register bytes needed to hold n input bits.
    function automatic int bytes_for(input int n);
        return (n + 7) / 8;
    endfunction

endpackage

// File: rtl/bus_interface_inputs_debouncer.sv
// Per-bit debouncer: accepts a new level only after it has differed from the
// current state on STABLE_TICKS consecutive sample ticks.
module input_debouncer #(
    parameter int STABLE_TICKS = 4
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic tick,
    input  logic raw_sync,
    input  logic armed,
    output logic state,
    output logic change_ev
);

    localparam int CW = $clog2(STABLE_TICKS + 1);

    logic [CW-1:0] cnt_r;
    logic          state_r;
    logic          change_ev_r;

    // Tick-driven stability counter; flipping clears it, so it never passes STABLE_TICKS-1.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cnt_r       <= '0;
            state_r     <= 1'b0;
            change_ev_r <= 1'b0;
        end else begin
            change_ev_r <= 1'b0;
            if (tick) begin
                if (raw_sync == state_r) begin
                    cnt_r <= '0;
                end else if (cnt_r >= CW'(STABLE_TICKS - 1)) begin
                    state_r     <= ~state_r;
                    cnt_r       <= '0;
                    change_ev_r <= armed;
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end
        end
    end

    assign state     = state_r;
    assign change_ev = change_ev_r;

endmodule

// File: rtl/bus_interface_inputs.sv
// Bus-mapped input peripheral: synchronised, debounced inputs with sticky
// change flags, a mask bank and a level interrupt acknowledged by the CPU.
module bus_interface_inputs
    import bus_interface_inputs_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR    = 8'hC2,
    parameter int         N_INPUTS     = 16,
    parameter int         TICK_DIV     = 50000,
    parameter int         STABLE_TICKS = 4,
    parameter int         IRQ_EN       = 1
) (
    input  logic                CLK,
    input  logic                RESETN,
    inout  wire  [7:0]          BUS_DATA,
    input  logic [7:0]          BUS_ADDR,
    input  logic                BUS_WE,
    output logic                INT_RAISE,
    input  logic                INT_ACK,
    input  logic [N_INPUTS-1:0] INPUTS
);

    localparam int         NB        = bytes_for(N_INPUTS);
    localparam int         PW        = $clog2(TICK_DIV);
    localparam int         AW        = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic       IRQ_ON    = (IRQ_EN != 0);

    logic [N_INPUTS-1:0] sync1_r, sync2_r;
    logic [N_INPUTS-1:0] state_s, change_ev_s;
    logic [N_INPUTS-1:0] change_r, mask_r, mask_d_r;
    logic [N_INPUTS-1:0] bank_vec_s, clr_s, mask_next_s;
    logic [PW-1:0]       presc_r;
    logic                tick_s;
    logic [AW-1:0]       arm_cnt_r;
    logic                armed_r;
    logic [7:0]          offset_s, byte_idx_s;
    bank_e               bank_s;
    logic [7:0]          rd_byte_s, rd_data_r;
    logic                rd_en_r;
    irq_state_e          irq_state_r, irq_state_next_s;
    logic                pend_s, pend_r, evm_r, trigger_s;

    assign tick_s = (presc_r == TICK_LAST);

    // Input synchronisers, sample prescaler and the power-up arming window.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync1_r   <= '0;
            sync2_r   <= '0;
            presc_r   <= '0;
            arm_cnt_r <= '0;
            armed_r   <= 1'b0;
        end else begin
            sync1_r <= INPUTS;
            sync2_r <= sync1_r;
            presc_r <= tick_s ? '0 : presc_r + PW'(1);
            if (tick_s && !armed_r) begin
                arm_cnt_r <= arm_cnt_r + AW'(1);
                armed_r   <= (arm_cnt_r == AW'(STABLE_TICKS - 1));
            end
        end
    end

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_deb
        input_debouncer #(.STABLE_TICKS(STABLE_TICKS)) u_deb (
            .CLK       (CLK),
            .RESETN    (RESETN),
            .tick      (tick_s),
            .raw_sync  (sync2_r[i]),
            .armed     (armed_r),
            .state     (state_s[i]),
            .change_ev (change_ev_s[i])
        );
    end

    // Address decode relative to BASE_ADDR; wrap-around keeps lower addresses out of range.
    always_comb begin
        offset_s   = BUS_ADDR - BASE_ADDR;
        bank_s     = BANK_NONE;
        byte_idx_s = 8'd0;
        if (offset_s < 8'(NB)) begin
            bank_s     = BANK_STATE;
            byte_idx_s = offset_s;
        end else if (offset_s < 8'(2 * NB)) begin
            bank_s     = BANK_CHANGE;
            byte_idx_s = offset_s - 8'(NB);
        end else if (offset_s < 8'(3 * NB)) begin
            bank_s     = BANK_MASK;
            byte_idx_s = offset_s - 8'(2 * NB);
        end else begin
            bank_s     = BANK_NONE;
            byte_idx_s = 8'd0;
        end
    end

    // Read byte mux plus the per-bit W1C and mask-write vectors of the addressed byte.
    always_comb begin
        case (bank_s)
            BANK_STATE:  bank_vec_s = state_s;
            BANK_CHANGE: bank_vec_s = change_r;
            BANK_MASK:   bank_vec_s = mask_r;
            default:     bank_vec_s = '0;
        endcase
        rd_byte_s   = 8'd0;
        clr_s       = '0;
        mask_next_s = mask_r;
        for (int b = 0; b < N_INPUTS; b++) begin
            rd_byte_s[b % 8] = rd_byte_s[b % 8] | (bank_vec_s[b] & (byte_idx_s == 8'(b / 8)));
            clr_s[b] = BUS_WE && (bank_s == BANK_CHANGE) && (byte_idx_s == 8'(b / 8)) && BUS_DATA[b % 8];
            mask_next_s[b] = (BUS_WE && (bank_s == BANK_MASK) && (byte_idx_s == 8'(b / 8)))
                             ? BUS_DATA[b % 8] : mask_r[b];
        end
    end

    // Register banks and the one-cycle read pipeline; set beats clear on change flags.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            change_r  <= '0;
            mask_r    <= '0;
            mask_d_r  <= '0;
            rd_en_r   <= 1'b0;
            rd_data_r <= 8'd0;
        end else begin
            change_r  <= (change_r & ~clr_s) | change_ev_s;
            mask_r    <= mask_next_s;
            mask_d_r  <= mask_r;
            rd_en_r   <= !BUS_WE && (bank_s != BANK_NONE);
            rd_data_r <= rd_byte_s;
        end
    end

    assign BUS_DATA = rd_en_r ? rd_data_r : 8'hzz;

    // A trigger is pend rising, a masked event, or a mask bit newly enabled over a set flag.
    assign pend_s    = |(change_r & mask_r);
    assign trigger_s = IRQ_ON & ((pend_s & ~pend_r) | evm_r | (|(change_r & mask_r & ~mask_d_r)));

    // IRQ state register and trigger history.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            irq_state_r <= IRQ_IDLE;
            pend_r      <= 1'b0;
            evm_r       <= 1'b0;
        end else begin
            irq_state_r <= irq_state_next_s;
            pend_r      <= pend_s;
            evm_r       <= |(change_ev_s & mask_r);
        end
    end

    // IRQ next state: an acknowledge only drops the request if no new trigger coincides.
    always_comb begin
        irq_state_next_s = irq_state_r;
        case (irq_state_r)
            IRQ_IDLE: begin
                if (trigger_s) irq_state_next_s = IRQ_RAISED;
                else           irq_state_next_s = IRQ_IDLE;
            end
            IRQ_RAISED: begin
                if (INT_ACK && !trigger_s) irq_state_next_s = IRQ_IDLE;
                else                       irq_state_next_s = IRQ_RAISED;
            end
            default: irq_state_next_s = IRQ_IDLE;
        endcase
    end

    assign INT_RAISE = (irq_state_r == IRQ_RAISED);

endmodule

// File: tb/tb_bus_interface_inputs.sv
// Directed bench: three peripheral instances (16, 5 and 20 inputs) share one
// pulled-up bus at distinct base addresses, so an undriven bus reads 8'hFF.
module tb_bus_interface_inputs;

    localparam logic [7:0] IDLE_ADDR = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  addr;
    logic        we;
    logic        ack;
    logic [7:0]  drv;
    logic        drv_en;
    tri1  [7:0]  bus;
    logic [15:0] in16;
    logic [4:0]  in5;
    logic [19:0] in20;
    logic        irq16, irq5, irq20;
    int          cmp_cnt = 0;
    int          fail_cnt = 0;
    int          cyc;

    always #5 clk = ~clk;

    assign bus = drv_en ? drv : 8'hzz;

    bus_interface_inputs #(.BASE_ADDR(8'hC2), .N_INPUTS(16), .TICK_DIV(4), .STABLE_TICKS(3), .IRQ_EN(1)) u_dut16 (
        .CLK(clk), .RESETN(rst_n), .BUS_DATA(bus), .BUS_ADDR(addr), .BUS_WE(we),
        .INT_RAISE(irq16), .INT_ACK(ack), .INPUTS(in16));
    bus_interface_inputs #(.BASE_ADDR(8'h10), .N_INPUTS(5), .TICK_DIV(4), .STABLE_TICKS(3), .IRQ_EN(1)) u_dut5 (
        .CLK(clk), .RESETN(rst_n), .BUS_DATA(bus), .BUS_ADDR(addr), .BUS_WE(we),
        .INT_RAISE(irq5), .INT_ACK(ack), .INPUTS(in5));
    bus_interface_inputs #(.BASE_ADDR(8'h20), .N_INPUTS(20), .TICK_DIV(4), .STABLE_TICKS(3), .IRQ_EN(1)) u_dut20 (
        .CLK(clk), .RESETN(rst_n), .BUS_DATA(bus), .BUS_ADDR(addr), .BUS_WE(we),
        .INT_RAISE(irq20), .INT_ACK(ack), .INPUTS(in20));

    // Edges since reset release; ticks land on edges where this is a multiple of 4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        logic [7:0] addr;
        logic       we;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[18];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; we = 1'b1; drv = d; drv_en = 1'b1;
        @(negedge clk);
        addr = IDLE_ADDR; we = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; we = 1'b0;
        @(negedge clk);
        d = bus;
        addr = IDLE_ADDR;
    endtask

    task automatic read_check(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic wait_irq(input int max, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (irq16) seen = 1'b1;
        end
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        vt[0]  = '{8'hC2, 1'b0, 8'h00, 8'h5A};
        vt[1]  = '{8'hC3, 1'b0, 8'h00, 8'hA5};
        vt[2]  = '{8'hC4, 1'b0, 8'h00, 8'h00};
        vt[3]  = '{8'hC5, 1'b0, 8'h00, 8'h00};
        vt[4]  = '{8'hC2, 1'b1, 8'h00, 8'h00};
        vt[5]  = '{8'hC2, 1'b0, 8'h00, 8'h5A};
        vt[6]  = '{8'hC6, 1'b1, 8'h01, 8'h00};
        vt[7]  = '{8'hC6, 1'b0, 8'h00, 8'h01};
        vt[8]  = '{8'hC7, 1'b1, 8'hF0, 8'h00};
        vt[9]  = '{8'hC7, 1'b0, 8'h00, 8'hF0};
        vt[10] = '{8'hC7, 1'b1, 8'h00, 8'h00};
        vt[11] = '{8'h10, 1'b0, 8'h00, 8'h1F};
        vt[12] = '{8'h12, 1'b1, 8'hFF, 8'h00};
        vt[13] = '{8'h12, 1'b0, 8'h00, 8'h1F};
        vt[14] = '{8'h22, 1'b0, 8'h00, 8'h0F};
        vt[15] = '{8'h28, 1'b1, 8'hFF, 8'h00};
        vt[16] = '{8'h28, 1'b0, 8'h00, 8'h0F};
        vt[17] = '{8'h11, 1'b0, 8'h00, 8'h00};

        rst_n = 1'b0; addr = IDLE_ADDR; we = 1'b0; ack = 1'b0; drv = 8'h00; drv_en = 1'b0;
        in16 = 16'hA55A; in5 = 5'h1F; in20 = 20'hFFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_irq16", {7'd0, irq16}, 8'h00);
        check("rst_irq5", {7'd0, irq5}, 8'h00);
        check("rst_irq20", {7'd0, irq20}, 8'h00);
        check("rst_bus_z", bus, 8'hFF);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("armed_no_irq", {7'd0, irq16}, 8'h00);

        for (int i = 0; i < 18; i++) begin
            if (vt[i].we) bus_write(vt[i].addr, vt[i].data);
            else          read_check($sformatf("vec%0d", i), vt[i].addr, vt[i].exp);
        end
        check("table_no_irq", {7'd0, irq16 | irq5 | irq20}, 8'h00);

        // Glitch of at most two ticks must be rejected.
        @(negedge clk); in16[0] = 1'b1;
        repeat (6) @(negedge clk);
        in16[0] = 1'b0;
        repeat (20) @(negedge clk);
        read_check("glitch_state", 8'hC2, 8'h5A);
        read_check("glitch_change", 8'hC4, 8'h00);
        check("glitch_irq", {7'd0, irq16}, 8'h00);

        // Stable change on a masked bit raises the interrupt; ack drops it next cycle.
        in16[0] = 1'b1;
        wait_irq(40, seen);
        check("irq_rise", {7'd0, seen}, 8'h01);
        read_check("accept_state", 8'hC2, 8'h5B);
        read_check("accept_change", 8'hC4, 8'h01);
        pulse_ack();
        check("irq_ack_fall", {7'd0, irq16}, 8'h00);
        bus_write(8'hC4, 8'h01);
        read_check("w1c_clear", 8'hC4, 8'h00);
        check("irq_after_w1c", {7'd0, irq16}, 8'h00);

        // Read latency and out-of-range addresses.
        @(negedge clk); addr = 8'hC3; we = 1'b0;
        #1 check("lat_req_cycle_z", bus, 8'hFF);
        @(negedge clk);
        check("lat_data", bus, 8'hA5);
        addr = IDLE_ADDR;
        @(negedge clk);
        check("lat_release_z", bus, 8'hFF);
        read_check("oor_above", 8'hC8, 8'hFF);
        read_check("oor_below", 8'hC1, 8'hFF);

        // W1C on bit3 captured on the same edge its change_ev is recorded.
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (cyc % 4 == 0) seen = 1'b1;
        end
        in16[3] = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        addr = 8'hC4; we = 1'b1; drv = 8'h08; drv_en = 1'b1;
        @(negedge clk);
        addr = IDLE_ADDR; we = 1'b0; drv_en = 1'b0;
        read_check("set_wins", 8'hC4, 8'h08);
        read_check("bit3_state", 8'hC2, 8'h53);

        // Enabling a mask bit over a set flag raises the interrupt.
        bus_write(8'hC6, 8'h09);
        wait_irq(4, seen);
        check("mask_enable_irq", {7'd0, seen}, 8'h01);
        pulse_ack();
        check("mask_ack_fall", {7'd0, irq16}, 8'h00);
        bus_write(8'hC4, 8'h08);
        bus_write(8'hC6, 8'h01);
        read_check("bit3_cleared", 8'hC4, 8'h00);

        // Reset asserted mid-read and mid-debounce, between clock edges.
        in16[0] = 1'b0;
        wait_irq(40, seen);
        check("pre_rst_irq", {7'd0, seen}, 8'h01);
        in16[5] = 1'b1;
        repeat (5) @(negedge clk);
        addr = 8'hC2; we = 1'b0;
        @(posedge clk);
        #2 check("pre_rst_read", bus, 8'h52);
        rst_n = 1'b0;
        #1 check("rst_bus_release", bus, 8'hFF);
        check("rst_irq_low", {7'd0, irq16}, 8'h00);
        addr = IDLE_ADDR;
        @(negedge clk); rst_n = 1'b1;
        repeat (40) @(negedge clk);
        read_check("post_rst_change0", 8'hC4, 8'h00);
        read_check("post_rst_change1", 8'hC5, 8'h00);
        read_check("post_rst_state0", 8'hC2, 8'h72);
        read_check("post_rst_state1", 8'hC3, 8'hA5);
        read_check("post_rst_mask0", 8'hC6, 8'h00);
        check("post_rst_irq", {7'd0, irq16}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
